bin2bcd_seq_converter: RTL and testbench

- Sequential double-dabble converter: turns a 7-bit binary operand into a 2-digit packed BCD byte.
- Sits directly upstream of the 8-bit BCD adder and produces its a/b operands, so binary sources can feed the decimal datapath.
- Converts one operand at a time, one shift per clock.
- Uses a valid/ready handshake on both sides.

---
 rtl/bin2bcd_seq_converter_if.sv | 21 ++
 rtl/bin2bcd_seq_converter.sv | 121 ++++++++++++
 tb/tb_bin2bcd_seq_converter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_converter_if.sv
// bin2bcd_seq_converter_if: valid/ready bundle for the binary-to-BCD converter.
// slave = converter side, master = producer/consumer side.
interface bin2bcd_seq_converter_if;
  logic [6:0] in_bin;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_bcd;
  logic       out_ovr;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_bin, in_valid, out_ready,
    output in_ready, out_bcd, out_ovr, out_valid
  );

  modport master (
    output in_bin, in_valid, out_ready,
    input  in_ready, out_bcd, out_ovr, out_valid
  );
endinterface

// File: rtl/bin2bcd_seq_converter.sv
// bin2bcd_seq_converter: 7-bit binary to 2-digit BCD, double-dabble, 1 shift/clk.
// Option macro BIN2BCD_SATURATE_EN: overrange operands read 8'h99 instead of low digits.
module bin2bcd_seq_converter (
  input  logic                           clk,
  input  logic                           rst,
  bin2bcd_seq_converter_if.slave         bus
);

  localparam int BIN_W  = 7;
  localparam int SHIFTS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [11:0]        bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [7:0]         out_bcd_q, out_bcd_d;
  logic               out_ovr_q, out_ovr_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [11:0]        adj;
  logic [19:0]        sh;
  logic               ovr;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Digit correction then one-bit left shift of {bcd,bin}; top bit is
  // always zero for a 7-bit operand but is folded into the overrange test.
  always_comb begin
    adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    sh  = {adj, bin_q, 1'b0};
    ovr = |sh[19:15];
  end

  // Next-state and registered-output computation for the FSM.
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    out_bcd_d   = out_bcd_q;
    out_ovr_d   = out_ovr_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d      = bus.in_bin;
          bcd_d      = '0;
          cnt_d      = 3'(SHIFTS);
          state_d    = SHIFT;
          in_ready_d = 1'b0;
        end
      end
      SHIFT: begin
        bcd_d = sh[18:7];
        bin_d = sh[6:0];
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_ovr_d   = ovr;
`ifdef BIN2BCD_SATURATE_EN
          out_bcd_d   = ovr ? 8'h99 : sh[14:7];
`else
          out_bcd_d   = sh[14:7];
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= 8'h00;
      out_ovr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      out_bcd_q   <= out_bcd_d;
      out_ovr_q   <= out_ovr_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_bcd   = out_bcd_q;
  assign bus.out_ovr   = out_ovr_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bin2bcd_seq_converter.sv
// tb_bin2bcd_seq_converter: directed checks of bin2bcd_seq_converter.
// Honors BIN2BCD_SATURATE_EN for overrange expectations.
module tb_bin2bcd_seq_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  bin2bcd_seq_converter_if bus();

  bin2bcd_seq_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_model(input int v);
    int r;
    logic [7:0] b;
    r = v % 100;
    b = {4'(r / 10), 4'(r % 10)};
`ifdef BIN2BCD_SATURATE_EN
    if (v > 99) b = 8'h99;
`endif
    return {(v > 99) ? 1'b1 : 1'b0, b};
  endfunction

  // Wait (bounded) for in_ready, present one operand for one edge.
  task automatic start(input logic [6:0] v);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_bin   = v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("busy_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  // Run the 7 shift edges, check latency and result, then consume it.
  task automatic finish_conv(input string tag, input logic [7:0] eb,
                             input logic eo);
    for (int i = 0; i < 6; i++) tick();
    chk({tag, "_valid_early"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_bcd"}, 32'(bus.out_bcd), 32'(eb));
    chk({tag, "_ovr"}, 32'(bus.out_ovr), 32'(eo));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  logic [8:0] m;
  logic [7:0] ovr_100, ovr_127;

  initial begin
    bus.in_bin    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
`ifdef BIN2BCD_SATURATE_EN
    ovr_100 = 8'h99;
    ovr_127 = 8'h99;
`else
    ovr_100 = 8'h00;
    ovr_127 = 8'h27;
`endif

    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_bcd", 32'(bus.out_bcd), 32'h00);
    chk("rst_out_ovr", 32'(bus.out_ovr), 32'd0);
    rst = 1'b0;
    tick();

    start(7'd42);
    finish_conv("v42", 8'h42, 1'b0);

    start(7'd0);   finish_conv("v0", 8'h00, 1'b0);
    start(7'd9);   finish_conv("v9", 8'h09, 1'b0);
    start(7'd10);  finish_conv("v10", 8'h10, 1'b0);
    start(7'd99);  finish_conv("v99", 8'h99, 1'b0);
    start(7'd100); finish_conv("v100", ovr_100, 1'b1);
    start(7'd127); finish_conv("v127", ovr_127, 1'b1);

    // Back-pressure: result held, new operand ignored.
    start(7'd57);
    for (int i = 0; i < 7; i++) tick();
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.in_bin   = 7'd3;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_bcd", 32'(bus.out_bcd), 32'h57);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    start(7'd63);
    finish_conv("v63", 8'h63, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    start(7'd88);
    for (int i = 0; i < 2; i++) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_bcd", 32'(bus.out_bcd), 32'h00);
    #1;
    rst = 1'b0;
    tick();
    start(7'd15);
    finish_conv("v15", 8'h15, 1'b0);

    // Sweep of every operand against the arithmetic reference.
    for (int v = 0; v < 128; v++) begin
      m = ref_model(v);
      start(7'(v));
      finish_conv("sweep", m[7:0], m[8]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
